// File: rtl/runner_pkg.sv
// rtl/runner_pkg.sv - shared game types: score FSM state encoding and default score width
package runner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } score_state_t;

  localparam int SCORE_DIGITS = 4;

endpackage

// File: rtl/bcd_incrementer.sv
// rtl/bcd_incrementer.sv - combinational saturating BCD +1 with hundred-wrap flag
module bcd_incrementer #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] value_inc,
  output logic                saturated,
  output logic                hundred_wrap
);

  logic [4*DIGITS-1:0] ripple;
  logic                carry;
  logic                all_nines;
  logic [3:0]          digit;

  always_comb begin
    ripple    = value;
    carry     = 1'b1;
    all_nines = 1'b1;
    digit     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      all_nines = all_nines & (digit == 4'd9);
      if (carry) begin
        if (digit == 4'd9) begin
          ripple[4*i +: 4] = 4'd0;
        end else begin
          ripple[4*i +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // A full-nines score holds rather than rolling over to zero.
  assign saturated = all_nines;
  assign value_inc = all_nines ? value : ripple;

  if (DIGITS >= 3) begin : g_wrap
    assign hundred_wrap = !all_nines && (value[7:0] == 8'h99);
  end else begin : g_nowrap
    assign hundred_wrap = 1'b0;
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game FSM, frame counting, saturating BCD score and display packing
// SCORE_HIGH_SCORE_EN builds the high-score register and the upper half of display.
module score_keeper
  import runner_pkg::*;
#(
  parameter int DIGITS           = SCORE_DIGITS,
  parameter int FRAMES_PER_POINT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_done,
  input  logic                start,
  input  logic                crash,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] high_bcd,
  output logic [31:0]         display,
  output logic                milestone,
  output logic [1:0]          state
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_POINT - 1);

  score_state_t  state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_prev_q, frame_prev_d;
  logic          milestone_q, milestone_d;
  logic [SW-1:0] score_inc;
  logic          score_sat;
  logic          score_wrap;
  logic          rise;
  logic          ending;

  bcd_incrementer #(.DIGITS(DIGITS)) u_inc (
    .value        (score_q),
    .value_inc    (score_inc),
    .saturated    (score_sat),
    .hundred_wrap (score_wrap)
  );

  assign rise = frame_done & ~frame_prev_q;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    cnt_d        = cnt_q;
    frame_prev_d = frame_done;
    milestone_d  = 1'b0;
    ending       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          score_d = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Crash wins over a frame finishing in the same cycle.
        if (crash) begin
          state_d = OVER;
          ending  = 1'b1;
        end else if (rise) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            score_d     = score_inc;
            milestone_d = score_wrap & ~score_sat;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (start && !crash) begin
          state_d = RUN;
          score_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      score_q      <= '0;
      cnt_q        <= '0;
      frame_prev_q <= 1'b0;
      milestone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      frame_prev_q <= frame_prev_d;
      milestone_q  <= milestone_d;
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [SW-1:0] high_q, high_d;

  // BCD preserves numeric order, so a plain binary compare is sufficient.
  always_comb begin
    high_d = high_q;
    if (ending && (score_q > high_q)) high_d = score_q;
  end

  always_ff @(posedge clk) begin
    if (rst) high_q <= '0;
    else     high_q <= high_d;
  end

  assign high_bcd = high_q;

  always_comb begin
    display           = '0;
    display[SW-1:0]   = score_q;
    display[16 +: SW] = high_q;
  end
`else
  logic unused_ending;
  assign unused_ending = ending;
  assign high_bcd      = '0;

  always_comb begin
    display         = '0;
    display[SW-1:0] = score_q;
  end
`endif

  assign score_bcd = score_q;
  assign milestone = milestone_q;
  assign state     = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench: two configurations checked against an integer game model
module tb_score_keeper;

`ifdef SCORE_HIGH_SCORE_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, frame_done = 1'b0, start = 1'b0, crash = 1'b0;

  logic [15:0] score_a, high_a;
  logic [31:0] disp_a;
  logic        ms_a;
  logic [1:0]  st_a;
  logic [11:0] score_b, high_b;
  logic [31:0] disp_b;
  logic        ms_b;
  logic [1:0]  st_b;

  score_keeper #(.DIGITS(4), .FRAMES_PER_POINT(6)) dut_a (
    .clk(clk), .rst(rst), .frame_done(frame_done), .start(start), .crash(crash),
    .score_bcd(score_a), .high_bcd(high_a), .display(disp_a), .milestone(ms_a), .state(st_a)
  );

  score_keeper #(.DIGITS(3), .FRAMES_PER_POINT(1)) dut_b (
    .clk(clk), .rst(rst), .frame_done(frame_done), .start(start), .crash(crash),
    .score_bcd(score_b), .high_bcd(high_b), .display(disp_b), .milestone(ms_b), .state(st_b)
  );

  typedef struct {
    int st;
    int score;
    int high;
    int cnt;
    bit prev;
    bit ms;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic mdl_t step(mdl_t m, bit r, bit fd, bit s, bit c, int fpp, int maxs);
    mdl_t n;
    bit   rise;
    n = m;
    if (r) begin
      n.st = 0; n.score = 0; n.high = 0; n.cnt = 0; n.prev = 0; n.ms = 0;
      return n;
    end
    rise   = fd && !m.prev;
    n.prev = fd;
    n.ms   = 1'b0;
    case (m.st)
      0: if (s) begin n.st = 1; n.score = 0; n.cnt = 0; end
      1: begin
        if (c) begin
          n.st = 2;
          if (m.score > m.high) n.high = m.score;
        end else if (rise) begin
          if (m.cnt == fpp - 1) begin
            n.cnt = 0;
            if (m.score < maxs) begin
              n.score = m.score + 1;
              n.ms    = (maxs >= 999) && (n.score % 100 == 0);
            end
          end else begin
            n.cnt = m.cnt + 1;
          end
        end
      end
      2: if (s && !c) begin n.st = 1; n.score = 0; n.cnt = 0; end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit fd, input bit s, input bit c);
    exp_t e;
    rst = r; frame_done = fd; start = s; crash = c;
    @(posedge clk);
    ma = step(ma, r, fd, s, c, 6, 9999);
    mb = step(mb, r, fd, s, c, 1, 999);
    e.a = ma;
    e.b = mb;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] ea, eb, ha, hb;
    if (q.size() > 0) begin
      e  = q.pop_front();
      ha = HEN ? to_bcd(e.a.high) : 32'd0;
      hb = HEN ? to_bcd(e.b.high) : 32'd0;
      ea = {ha[15:0], to_bcd(e.a.score)[15:0]};
      eb = {4'd0, hb[11:0], 4'd0, to_bcd(e.b.score)[11:0]};
      chk("a_state", {30'd0, st_a}, 32'(e.a.st));
      chk("a_score", {16'd0, score_a}, to_bcd(e.a.score) & 32'h0000_ffff);
      chk("a_high", {16'd0, high_a}, {16'd0, ha[15:0]});
      chk("a_display", disp_a, ea);
      chk("a_milestone", {31'd0, ms_a}, {31'd0, e.a.ms});
      chk("b_state", {30'd0, st_b}, 32'(e.b.st));
      chk("b_score", {20'd0, score_b}, to_bcd(e.b.score) & 32'h0000_0fff);
      chk("b_high", {20'd0, high_b}, {20'd0, hb[11:0]});
      chk("b_display", disp_b, eb);
      chk("b_milestone", {31'd0, ms_b}, {31'd0, e.b.ms});
    end
  end

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_score", {16'd0, score_a}, 32'd0);
    chk("reset_state", {30'd0, st_a}, 32'd0);

    cyc(0, 0, 1, 0);
    repeat (12) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("plan_12_frames_score", {16'd0, score_a}, 32'h0000_0002);
    chk("plan_12_frames_state", {30'd0, st_a}, 32'd1);

    repeat (50) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_high_once", {20'd0, score_b}, 32'h0000_0013);

    repeat (1100) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("b_saturated", {20'd0, score_b}, 32'h0000_0999);
    cyc(0, 1, 0, 1);
    chk("crash_state", {30'd0, st_a}, 32'd2);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (42) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    repeat (17) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 1);
    chk("plan_display", disp_b, HEN ? 32'h0042_0017 : 32'h0000_0017);

    repeat (3000) begin
      cyc($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
    end

    cyc(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
